udp_app_frame_gen: RTL and testbench
====================================

Name: udp_app_frame_gen

Overview:
- Application-side frame writer that drives the write (transmit) stream of the UDP top level: wr_data/wr_valid/wr_last, with wr_ready as backpressure.
- Emits numbered test frames: one header beat, then counter payload, then a programmable inter-frame gap.
- Used for link bring-up, throughput measurement and loopback testing, in the same clock domain as the UDP top's wr_clk.

Parameters:
- DATA_W, 64, beat width; must be >= 64 and must match the UDP top's DATA_W.
- LEN_W, 16, width of the beats-per-frame configuration.
- GAP_W, 16, width of the inter-frame gap configuration.

Ports:
- clk  in  1  sole clock; all logic is in this domain.
- rstn  in  1  reset, synchronous, active-low.
- enable  in  1  level; high starts or continues generation.
- cfg_frame_beats  in  LEN_W  beats per frame, header included; 0 is treated as 1.
- cfg_gap_cycles  in  GAP_W  idle cycles between frames.
- cfg_frame_count  in  32  frames per run; 0 means unlimited.
- wr_data  out  DATA_W  stream data.
- wr_valid  out  1  stream valid.
- wr_last  out  1  final beat of a frame.
- wr_ready  in  1  stream ready.
- busy  out  1  high in any state other than IDLE or DONE.
- done  out  1  high while in DONE.
- frames_sent  out  32  frames completed in the current run.

Behaviour:
- Reset: state IDLE; wr_valid, wr_last, busy, done = 0; wr_data = 0; frames_sent = 0; seq = 0. Reset mid-frame drops the frame immediately; no wr_last is emitted.
- Handshake: a beat transfers when wr_valid && wr_ready. While wr_valid is high and wr_ready is low, wr_data and wr_last hold stable. wr_valid never drops without a transfer.
- IDLE:
  - On enable = 1: latch cfg_*, clear seq and frames_sent, go to HDR.
  - wr_valid rises on the next cycle (1-cycle latency).
- HDR:
  - wr_data = {zero-fill, 16'hA55A, beats[15:0], seq[31:0]}.
  - wr_last = (beats == 1).
  - On transfer: go to PAY with beat index = 1, or take the end-of-frame path if beats == 1.
- PAY:
  - wr_data = {zero-fill, seq[31:0], idx[31:0]}.
  - wr_last = (idx == beats-1).
  - idx increments on each transfer.
- End of frame (the wr_last transfer):
  - seq and frames_sent increment, both 32-bit wrapping.
  - If cfg_frame_count != 0 and frames_sent+1 == cfg_frame_count: go to DONE.
  - Else if enable == 0: go to IDLE.
  - Else if gap == 0: go to HDR, and wr_valid stays high (back-to-back frames).
  - Else: go to GAP.
- GAP:
  - wr_valid = 0; count down gap cycles.
  - At count 0: if enable, re-latch cfg_* and go to HDR; else go to IDLE.
- DONE: done = 1, wr_valid = 0. Stays in DONE until enable == 0, then goes to IDLE. frames_sent holds its value.
- enable dropped mid-frame: the current frame completes in full; it is never truncated.
- cfg_* changes mid-frame have no effect; configuration is sampled only at frame start.
- Counter widths: idx is LEN_W bits. The header beats field is zero-extended or truncated to 16 bits.

Optional Feature:
- Macro: UDP_APP_FRAME_GEN_STATS_EN.
- When defined, adds three outputs:
  - stall_cycles [32]: counts cycles with wr_valid && !wr_ready.
  - beats_sent [32]: counts transfers.
  - max_stall [16]: the longest consecutive stall, saturating.
- All three clear on reset and on the IDLE->HDR run start, and wrap at 2^32 except max_stall, which saturates.
- When not defined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package udp_app_pkg holds:
  - the state enum (IDLE, HDR, PAY, GAP, DONE);
  - HDR_MAGIC = 16'hA55A;
  - the header field offsets.
- No sub-module is required. The optional stats counters are a natural sub-module: udp_app_stream_stats, which observes valid/ready only.

Test Plan:
- beats=4, gap=0, count=2, wr_ready=1:
  - 8 consecutive beats.
  - Beat0 = 0xA55A_0004_0000_0000; beat1 = 0x0000_0000_0000_0001.
  - wr_last on beats 3 and 7; frame 2 header seq = 1.
  - Then done = 1 and frames_sent = 2.
- beats=3, gap=5: exactly 5 cycles with wr_valid = 0 between one frame's wr_last transfer and the next header.
- beats=1 (and separately beats=0): every beat is a header with wr_last = 1; header beats field = 1 in both cases.
- Random wr_ready (50% duty), beats=16, count=10:
  - wr_data and wr_last stable during every stall.
  - 160 transfers total, payload idx contiguous.
  - With STATS_EN: beats_sent = 160 and stall_cycles equals the bench-counted stalls.
- enable dropped during beat 2 of an 8-beat frame: frame completes through idx 7 with wr_last, then IDLE with busy = 0 and no new header.
- rstn low during PAY with wr_ready = 0: the cycle after reset, wr_valid = 0, frames_sent = 0, state IDLE; re-enable yields seq = 0.

Source files
------------

// File: rtl/udp_app_pkg.sv
// Shared definitions for the UDP application-side frame generator:
// FSM state encoding, header magic and the bit offsets of the fields
// inside header and payload beats.
package udp_app_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        PAY  = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam logic [15:0] HDR_MAGIC = 16'hA55A;

    // Header beat: {zero-fill, magic[15:0], beats[15:0], seq[31:0]}
    localparam int HDR_SEQ_LSB   = 0;
    localparam int HDR_BEATS_LSB = 32;
    localparam int HDR_MAGIC_LSB = 48;

    // Payload beat: {zero-fill, seq[31:0], idx[31:0]}
    localparam int PAY_IDX_LSB   = 0;
    localparam int PAY_SEQ_LSB   = 32;

endpackage

// File: rtl/udp_app_stream_stats.sv
// Stream statistics observer for the frame generator write stream.
// Counts stall cycles and transfers, and tracks the longest run of
// consecutive stalls (saturating at 16 bits).
// Only built when UDP_APP_FRAME_GEN_STATS_EN is defined.
`ifdef UDP_APP_FRAME_GEN_STATS_EN
module udp_app_stream_stats (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        valid,
    input  logic        ready,
    output logic [31:0] stall_cycles,
    output logic [31:0] beats_sent,
    output logic [15:0] max_stall
);

    logic [31:0] stall_q, stall_d;
    logic [31:0] beats_q, beats_d;
    logic [15:0] max_q, max_d;
    logic [15:0] run_q, run_d;

    // Next-value logic for the counters and the stall run tracker
    always_comb begin
        stall_d = stall_q;
        beats_d = beats_q;
        max_d   = max_q;
        run_d   = run_q;
        if (clear) begin
            stall_d = '0;
            beats_d = '0;
            max_d   = '0;
            run_d   = '0;
        end else begin
            if (valid && ready) begin
                beats_d = beats_q + 32'd1;
            end
            if (valid && !ready) begin
                stall_d = stall_q + 32'd1;
                run_d   = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;
                if (run_d > max_q) begin
                    max_d = run_d;
                end
            end else begin
                run_d = '0;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_q <= '0;
            beats_q <= '0;
            max_q   <= '0;
            run_q   <= '0;
        end else begin
            stall_q <= stall_d;
            beats_q <= beats_d;
            max_q   <= max_d;
            run_q   <= run_d;
        end
    end

    assign stall_cycles = stall_q;
    assign beats_sent   = beats_q;
    assign max_stall    = max_q;

endmodule
`endif

// File: rtl/udp_app_frame_gen.sv
// Application-side test frame writer for the UDP top write stream.
// Emits numbered frames (header beat + counter payload) separated by a
// programmable idle gap. Optional stream statistics outputs are enabled
// with the macro UDP_APP_FRAME_GEN_STATS_EN.
module udp_app_frame_gen #(
    parameter int DATA_W = 64,
    parameter int LEN_W  = 16,
    parameter int GAP_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic [LEN_W-1:0]  cfg_frame_beats,
    input  logic [GAP_W-1:0]  cfg_gap_cycles,
    input  logic [31:0]       cfg_frame_count,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_valid,
    output logic              wr_last,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic [31:0]       frames_sent
`ifdef UDP_APP_FRAME_GEN_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       beats_sent,
    output logic [15:0]       max_stall
`endif
);
    import udp_app_pkg::*;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   beats_q, beats_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        seq_q, seq_d;
    logic [31:0]        frames_q, frames_d;
    logic               xfer, eof, load_cfg;
    logic [LEN_W-1:0]   cfg_beats_eff;

    // A zero-length frame still carries its header beat
    assign cfg_beats_eff = (cfg_frame_beats == '0) ? LEN_W'(1) : cfg_frame_beats;
    assign xfer          = wr_valid && wr_ready;

    // Stream outputs are a pure function of registered state, so they hold during stalls
    always_comb begin
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        wr_data  = '0;
        case (state_q)
            HDR: begin
                wr_valid = 1'b1;
                wr_last  = (beats_q == LEN_W'(1));
                wr_data[HDR_SEQ_LSB   +: 32] = seq_q;
                wr_data[HDR_BEATS_LSB +: 16] = 16'(beats_q);
                wr_data[HDR_MAGIC_LSB +: 16] = HDR_MAGIC;
            end
            PAY: begin
                wr_valid = 1'b1;
                wr_last  = (idx_q == beats_q - LEN_W'(1));
                wr_data[PAY_IDX_LSB +: 32] = 32'(idx_q);
                wr_data[PAY_SEQ_LSB +: 32] = seq_q;
            end
            default: ;
        endcase
    end

    // Next-state and counter logic
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        beats_d   = beats_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        count_d   = count_q;
        seq_d     = seq_q;
        frames_d  = frames_q;
        eof       = 1'b0;
        load_cfg  = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    load_cfg = 1'b1;
                    seq_d    = '0;
                    frames_d = '0;
                    state_d  = HDR;
                end
            end
            HDR: begin
                if (xfer) begin
                    if (wr_last) begin
                        eof = 1'b1;
                    end else begin
                        idx_d   = LEN_W'(1);
                        state_d = PAY;
                    end
                end
            end
            PAY: begin
                if (xfer) begin
                    if (wr_last) begin
                        eof = 1'b1;
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    if (enable) begin
                        load_cfg = 1'b1;
                        state_d  = HDR;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            DONE: begin
                if (!enable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // End of frame: the gap counter is loaded with gap-1 so GAP lasts exactly gap cycles
        if (eof) begin
            seq_d    = seq_q + 32'd1;
            frames_d = frames_q + 32'd1;
            if ((count_q != '0) && (frames_d == count_q)) begin
                state_d = DONE;
            end else if (!enable) begin
                state_d = IDLE;
            end else if (gap_q == '0) begin
                load_cfg = 1'b1;
                state_d  = HDR;
            end else begin
                gap_cnt_d = gap_q - GAP_W'(1);
                state_d   = GAP;
            end
        end

        // Configuration is only captured at a frame start
        if (load_cfg) begin
            beats_d = cfg_beats_eff;
            gap_d   = cfg_gap_cycles;
            count_d = cfg_frame_count;
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rstn) begin
            state_q   <= IDLE;
            beats_q   <= LEN_W'(1);
            idx_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            count_q   <= '0;
            seq_q     <= '0;
            frames_q  <= '0;
        end else begin
            state_q   <= state_d;
            beats_q   <= beats_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            count_q   <= count_d;
            seq_q     <= seq_d;
            frames_q  <= frames_d;
        end
    end

    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign done        = (state_q == DONE);
    assign frames_sent = frames_q;

`ifdef UDP_APP_FRAME_GEN_STATS_EN
    logic run_start;
    assign run_start = (state_q == IDLE) && enable;

    udp_app_stream_stats u_stats (
        .clk          (clk),
        .rstn         (rstn),
        .clear        (run_start),
        .valid        (wr_valid),
        .ready        (wr_ready),
        .stall_cycles (stall_cycles),
        .beats_sent   (beats_sent),
        .max_stall    (max_stall)
    );
`endif

endmodule

// File: tb/tb_udp_app_frame_gen.sv
// Self-checking bench for udp_app_frame_gen: table of run configurations
// checked against a scoreboard of expected beats, plus hand-written
// sequences for enable drop mid-frame and reset mid-payload.
module tb_udp_app_frame_gen;

    localparam int DATA_W = 64;
    localparam int LEN_W  = 16;
    localparam int GAP_W  = 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic              enable;
    logic [LEN_W-1:0]  cfg_frame_beats;
    logic [GAP_W-1:0]  cfg_gap_cycles;
    logic [31:0]       cfg_frame_count;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_last;
    logic              wr_ready;
    logic              busy;
    logic              done;
    logic [31:0]       frames_sent;
`ifdef UDP_APP_FRAME_GEN_STATS_EN
    logic [31:0]       stall_cycles;
    logic [31:0]       beats_sent;
    logic [15:0]       max_stall;
`endif

    always #5 clk = ~clk;

    udp_app_frame_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .enable          (enable),
        .cfg_frame_beats (cfg_frame_beats),
        .cfg_gap_cycles  (cfg_gap_cycles),
        .cfg_frame_count (cfg_frame_count),
        .wr_data         (wr_data),
        .wr_valid        (wr_valid),
        .wr_last         (wr_last),
        .wr_ready        (wr_ready),
        .busy            (busy),
        .done            (done),
        .frames_sent     (frames_sent)
`ifdef UDP_APP_FRAME_GEN_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .beats_sent      (beats_sent),
        .max_stall       (max_stall)
`endif
    );

    typedef struct {
        int beats;
        int gap;
        int count;
        bit rnd;
        int exp_xfers;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          xfer_cnt = 0;
    int          stall_cnt = 0;
    int          cur_run = 0;
    int          max_run = 0;
    int          gap_len = 0;
    int          exp_gap = 0;
    bit          in_gap = 1'b0;
    bit          mon_en = 1'b0;
    bit          rnd_ready = 1'b0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic        prev_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: expected beats for a run of nframes frames starting at seq 0
    task automatic push_frames(input int beats, input int nframes);
        int    eff;
        beat_t b;
        eff = (beats == 0) ? 1 : beats;
        for (int f = 0; f < nframes; f++) begin
            b.data = {16'hA55A, 16'(eff), 32'(f)};
            b.last = (eff == 1);
            exp_q.push_back(b);
            for (int i = 1; i < eff; i++) begin
                b.data = {32'(f), 32'(i)};
                b.last = (i == eff - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        xfer_cnt  = 0;
        stall_cnt = 0;
        cur_run   = 0;
        max_run   = 0;
    endtask

    // Random backpressure driver
    always @(posedge clk) begin
        if (rnd_ready) begin
            #1;
            wr_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: scoreboard, stall stability, inter-frame gap length
    always @(negedge clk) begin
        beat_t e;
        if (mon_en && rstn) begin
            if (in_gap) begin
                if (!wr_valid) begin
                    gap_len++;
                end else begin
                    check("gap_cycles", 64'(gap_len), 64'(exp_gap));
                    in_gap = 1'b0;
                end
            end
            if (prev_stall) begin
                check("stall_data_stable", wr_data, prev_data);
                check("stall_valid_last_stable", {62'd0, wr_valid, wr_last}, {62'd0, 1'b1, prev_last});
            end
            if (wr_valid && !wr_ready) begin
                stall_cnt++;
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
            end else begin
                cur_run = 0;
            end
            prev_stall = wr_valid && !wr_ready;
            prev_data  = wr_data;
            prev_last  = wr_last;
            if (wr_valid && wr_ready) begin
                xfer_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat actual=0x%0h expected=none", wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if ((wr_data !== e.data) || (wr_last !== e.last)) begin
                        failures++;
                        $display("FAIL beat actual=0x%0h/last%0b expected=0x%0h/last%0b",
                                 wr_data, wr_last, e.data, e.last);
                    end
                    if (e.last && exp_q.size() != 0) begin
                        in_gap  = 1'b1;
                        gap_len = 0;
                    end
                end
            end
        end else begin
            prev_stall = 1'b0;
            in_gap     = 1'b0;
            cur_run    = 0;
        end
    end

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        #1;
        check(name, 64'(done), 64'(1));
    endtask

    task automatic run_vec(input vec_t v, input int id);
        cfg_frame_beats = LEN_W'(v.beats);
        cfg_gap_cycles  = GAP_W'(v.gap);
        cfg_frame_count = 32'(v.count);
        exp_gap         = v.gap;
        exp_q.delete();
        push_frames(v.beats, v.count);
        clear_counters();
        if (!v.rnd) wr_ready = 1'b1;
        rnd_ready = v.rnd;
        step();
        enable = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d_valid_latency0", id), 64'(wr_valid), 64'(0));
        @(negedge clk);
        check($sformatf("v%0d_valid_rise", id), 64'(wr_valid), 64'(1));
        wait_done($sformatf("v%0d_done", id));
        check($sformatf("v%0d_frames_sent", id), 64'(frames_sent), 64'(v.count));
        check($sformatf("v%0d_xfers", id), 64'(xfer_cnt), 64'(v.exp_xfers));
        check($sformatf("v%0d_sb_left", id), 64'(exp_q.size()), 64'(0));
        check($sformatf("v%0d_done_idle_out", id), {61'd0, busy, wr_valid, wr_last}, 64'(0));
`ifdef UDP_APP_FRAME_GEN_STATS_EN
        check($sformatf("v%0d_beats_sent", id), 64'(beats_sent), 64'(xfer_cnt));
        check($sformatf("v%0d_stall_cycles", id), 64'(stall_cycles), 64'(stall_cnt));
        check($sformatf("v%0d_max_stall", id), 64'(max_stall), 64'(max_run));
`endif
        rnd_ready = 1'b0;
        step();
        wr_ready = 1'b1;
        enable   = 1'b0;
        step();
        check($sformatf("v%0d_back_to_idle", id), {62'd0, done, busy}, 64'(0));
        check($sformatf("v%0d_frames_hold", id), 64'(frames_sent), 64'(v.count));
    endtask

    vec_t vecs[5];

    initial begin
        int n;
        vecs[0] = '{beats: 4,  gap: 0, count: 2,  rnd: 1'b0, exp_xfers: 8};
        vecs[1] = '{beats: 3,  gap: 5, count: 2,  rnd: 1'b0, exp_xfers: 6};
        vecs[2] = '{beats: 1,  gap: 0, count: 3,  rnd: 1'b0, exp_xfers: 3};
        vecs[3] = '{beats: 0,  gap: 2, count: 3,  rnd: 1'b0, exp_xfers: 3};
        vecs[4] = '{beats: 16, gap: 1, count: 10, rnd: 1'b1, exp_xfers: 160};

        rstn            = 1'b0;
        enable          = 1'b0;
        wr_ready        = 1'b0;
        cfg_frame_beats = '0;
        cfg_gap_cycles  = '0;
        cfg_frame_count = '0;
        repeat (3) step();
        @(negedge clk);
        check("reset_data", wr_data, 64'(0));
        check("reset_ctrl", {59'd0, wr_valid, wr_last, busy, done, 1'b0}, 64'(0));
        check("reset_frames", 64'(frames_sent), 64'(0));
        step();
        rstn   = 1'b1;
        mon_en = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], i);
        end

        // Enable dropped while beat 2 of an 8-beat frame is on the bus
        cfg_frame_beats = LEN_W'(8);
        cfg_gap_cycles  = '0;
        cfg_frame_count = '0;
        exp_q.delete();
        push_frames(8, 1);
        clear_counters();
        wr_ready = 1'b1;
        step();
        enable = 1'b1;
        n = 0;
        while (xfer_cnt < 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        enable = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("drop_busy_low", 64'(busy), 64'(0));
        check("drop_xfers", 64'(xfer_cnt), 64'(8));
        check("drop_sb_left", 64'(exp_q.size()), 64'(0));
        check("drop_frames", 64'(frames_sent), 64'(1));
        repeat (4) begin
            @(negedge clk);
            check("drop_no_new_hdr", {62'd0, wr_valid, done}, 64'(0));
        end

        // Reset while a payload beat is stalled
        cfg_frame_beats = LEN_W'(8);
        exp_q.delete();
        push_frames(8, 1);
        clear_counters();
        step();
        enable = 1'b1;
        n = 0;
        while (xfer_cnt < 3 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        wr_ready = 1'b0;
        step();
        mon_en = 1'b0;
        exp_q.delete();
        rstn   = 1'b0;
        enable = 1'b0;
        step();
        @(negedge clk);
        check("rst_mid_valid_last", {62'd0, wr_valid, wr_last}, 64'(0));
        check("rst_mid_state", {62'd0, busy, done}, 64'(0));
        check("rst_mid_frames", 64'(frames_sent), 64'(0));
        step();
        rstn            = 1'b1;
        wr_ready        = 1'b1;
        cfg_frame_beats = LEN_W'(2);
        cfg_frame_count = 32'd1;
        push_frames(2, 1);
        clear_counters();
        mon_en = 1'b1;
        step();
        enable = 1'b1;
        wait_done("rst_reenable_done");
        check("rst_reenable_xfers", 64'(xfer_cnt), 64'(2));
        check("rst_reenable_sb_left", 64'(exp_q.size()), 64'(0));
        check("rst_reenable_frames", 64'(frames_sent), 64'(1));
        step();
        enable = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
